// File: rtl/n64_vbus_tx.sv
// -----------------------------------------------------------------------------
// n64_vbus_tx
//   Transmitter for the N64 RCP digital video bus (nVDSYNC + 7-bit multiplexed
//   VD). Produces a complete sync/pixel stream with selectable test patterns,
//   in the same format the PPU input stage decodes. Everything runs on VCLK.
//
//   Each pixel takes 4 VCLK cycles:
//     phase 0 : nVDSYNC=0, VD = {3'b000, nVSYNC, nCLAMP, nHSYNC, nCSYNC}
//     phase 1 : nVDSYNC=1, VD = R
//     phase 2 : nVDSYNC=1, VD = G
//     phase 3 : nVDSYNC=1, VD = B
//
// Ports
//   VCLK         in   1  video clock
//   VRST         in   1  synchronous reset, active high (priority over EN)
//   EN           in   1  stream enable; a rise restarts at line 0, pixel 0
//   INTERLACED   in   1  1 = 480i field sequence, 0 = 240p
//   PATTERN      in   2  0 black, 1 colour bars, 2 grey ramp, 3 checkerboard
//   nVDSYNC      out  1  low during the sync-word phase
//   VD           out  7  sync word or R/G/B sample
//   FIELD        out  1  current field (0 even, 1 odd); 0 when not interlaced
//   FRAME_START  out  1  one-cycle pulse alongside the line 0, pixel 0 sync word
// -----------------------------------------------------------------------------
module n64_vbus_tx #(
  parameter int H_TOTAL     = 773,
  parameter int H_SYNC      = 57,
  parameter int CLAMP_START = 62,
  parameter int CLAMP_LEN   = 30,
  parameter int H_ACT_START = 108,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 263,
  parameter int V_SYNC      = 3,
  parameter int V_ACT_START = 20,
  parameter int V_ACTIVE    = 240
) (
  input  logic       VCLK,
  input  logic       VRST,
  input  logic       EN,
  input  logic       INTERLACED,
  input  logic [1:0] PATTERN,
  output logic       nVDSYNC,
  output logic [6:0] VD,
  output logic       FIELD,
  output logic       FRAME_START
);

  // Counter widths are kept wide enough for the pattern generators, which
  // need x[6:0] (grey ramp) and y[3] (checkerboard) even for tiny timings.
  localparam int HW = ($clog2(H_TOTAL) < 7) ? 7 : $clog2(H_TOTAL);
  localparam int VW = ($clog2(V_TOTAL) < 4) ? 4 : $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_HALF   = HW'(H_TOTAL >> 1);
  localparam logic [HW-1:0] H_SYNC_C = HW'(H_SYNC);
  localparam logic [HW-1:0] C_LO     = HW'(CLAMP_START);
  localparam logic [HW-1:0] C_HI     = HW'(CLAMP_START + CLAMP_LEN);
  localparam logic [HW-1:0] H_ACT_LO = HW'(H_ACT_START);
  localparam logic [HW-1:0] H_ACT_N  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_C = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_LO = VW'(V_ACT_START);
  localparam logic [VW-1:0] V_ACT_N  = VW'(V_ACTIVE);

  // Colour-bar component masks, bit k = bar k, order W,Y,C,G,M,R,B,K.
  localparam logic [7:0] BAR_R = 8'b0011_0011;
  localparam logic [7:0] BAR_G = 8'b0000_1111;
  localparam logic [7:0] BAR_B = 8'b0101_0101;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    r_phase;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic          r_field;
  logic [1:0]    r_pattern;
  logic          r_en_q;        // EN seen last cycle; 0 after reset/disable
  logic          r_vdsync_n;
  logic [6:0]    r_vd;
  logic          r_frame_start;

  // ---------------------------------------------------------------------------
  // Combinational decode of the counter state
  // ---------------------------------------------------------------------------
  logic          w_origin;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_wrap;
  logic          w_hs;
  logic          w_vs;
  logic          w_clamp;
  logic [6:0]    w_sync_word;
  logic [HW-1:0] w_x;
  logic [VW-1:0] w_y;
  logic          w_active;
  logic [6:0]    w_bar_ge;
  logic [2:0]    w_bar;
  logic [6:0]    w_r;
  logic [6:0]    w_g;
  logic [6:0]    w_b;
  logic [6:0]    w_pix;

  assign w_origin = (r_phase == 2'd0) && (r_hcnt == '0) && (r_vcnt == '0);
  assign w_h_last = (r_hcnt == H_LAST);
  assign w_v_last = (r_vcnt == V_LAST);
  assign w_wrap   = (r_phase == 2'd3) && w_h_last && w_v_last;

  assign w_hs = (r_hcnt < H_SYNC_C);

  // Vertical sync in half-line units: field 1 shifts the window by half a
  // line, so it starts mid-line 0 and ends mid-line V_SYNC.
  always_comb begin
    w_vs = 1'b0;
    if (!r_field) begin
      w_vs = (r_vcnt < V_SYNC_C);
    end else begin
      w_vs = ((r_vcnt == '0) && (r_hcnt >= H_HALF)) ||
             ((r_vcnt != '0) && (r_vcnt < V_SYNC_C)) ||
             ((r_vcnt == V_SYNC_C) && (r_hcnt < H_HALF));
    end
  end

  // Clamp is suppressed during vsync.
  assign w_clamp = !w_vs && (r_hcnt >= C_LO) && (r_hcnt < C_HI);

  // Composite sync is the XOR, which yields inverted serration during vsync.
  assign w_sync_word = {3'b000, ~w_vs, ~w_clamp, ~w_hs, ~(w_hs ^ w_vs)};

  // x/y wrap to large values before the active start, so a single unsigned
  // compare against the active size covers both edges of each window.
  assign w_x      = r_hcnt - H_ACT_LO;
  assign w_y      = r_vcnt - V_ACT_LO;
  assign w_active = (w_x < H_ACT_N) && (w_y < V_ACT_N);

  // Bar boundaries are elaboration-time constants; one compare per boundary.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_bar_thr
      localparam logic [HW-1:0] THR = HW'(((gi + 1) * H_ACTIVE) / 8);
      assign w_bar_ge[gi] = (w_x >= THR);
    end
  endgenerate

  always_comb begin
    w_bar = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (w_bar_ge[k]) w_bar = 3'(k + 1);
    end
  end

  always_comb begin
    w_r = 7'h00;
    w_g = 7'h00;
    w_b = 7'h00;
    if (w_active) begin
      case (r_pattern)
        2'd1: begin
          w_r = BAR_R[w_bar] ? 7'h7F : 7'h00;
          w_g = BAR_G[w_bar] ? 7'h7F : 7'h00;
          w_b = BAR_B[w_bar] ? 7'h7F : 7'h00;
        end
        2'd2: begin
          w_r = w_x[6:0];
          w_g = w_x[6:0];
          w_b = w_x[6:0];
        end
        2'd3: begin
          w_r = (w_x[3] ^ w_y[3]) ? 7'h7F : 7'h00;
          w_g = w_r;
          w_b = w_r;
        end
        default: begin
          w_r = 7'h00;
          w_g = 7'h00;
          w_b = 7'h00;
        end
      endcase
    end
  end

  always_comb begin
    w_pix = 7'h00;
    case (r_phase)
      2'd1:    w_pix = w_r;
      2'd2:    w_pix = w_g;
      2'd3:    w_pix = w_b;
      default: w_pix = 7'h00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, sampled controls and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge VCLK) begin
    if (VRST) begin
      r_phase       <= 2'd0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_field       <= 1'b0;
      r_pattern     <= 2'd0;
      r_en_q        <= 1'b0;
      r_vdsync_n    <= 1'b1;
      r_vd          <= 7'h00;
      r_frame_start <= 1'b0;
    end else if (!EN) begin
      // Counters parked at the origin so the next rise starts a fresh frame.
      r_phase       <= 2'd0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_field       <= 1'b0;
      r_en_q        <= 1'b0;
      r_vdsync_n    <= 1'b1;
      r_vd          <= 7'h00;
      r_frame_start <= 1'b0;
    end else begin
      r_en_q        <= 1'b1;
      r_frame_start <= w_origin;
      r_vdsync_n    <= (r_phase != 2'd0);
      r_vd          <= (r_phase == 2'd0) ? w_sync_word : w_pix;

      r_phase <= r_phase + 2'd1;
      if (r_phase == 2'd3) begin
        r_hcnt <= w_h_last ? '0 : r_hcnt + HW'(1);
        if (w_h_last) begin
          r_vcnt <= w_v_last ? '0 : r_vcnt + VW'(1);
        end
      end

      // Pattern is latched at stream start and at every frame boundary only.
      if (!r_en_q) begin
        r_pattern <= PATTERN;
      end
      if (w_wrap) begin
        r_pattern <= PATTERN;
        r_field   <= INTERLACED ? ~r_field : 1'b0;
      end
    end
  end

  assign nVDSYNC     = r_vdsync_n;
  assign VD          = r_vd;
  assign FIELD       = r_field;
  assign FRAME_START = r_frame_start;

endmodule

// File: tb/tb_n64_vbus_tx.sv
// -----------------------------------------------------------------------------
// tb_n64_vbus_tx
//   Directed bench for n64_vbus_tx using a shrunken timing set so whole frames
//   fit in a short run. Expected bus values are worked out by hand from the
//   timing parameters below. "pos" counts VCLK cycles since the last observed
//   FRAME_START, so output at pos = 4*(line*H_TOTAL + pixel) + phase.
// -----------------------------------------------------------------------------
module tb_n64_vbus_tx;

  localparam int HT    = 41;   // half line = 20
  localparam int HS    = 4;
  localparam int CS    = 5;    // clamp pixels 5..7
  localparam int CL    = 3;
  localparam int HA    = 10;   // active pixels 10..33, bars 3 pixels wide
  localparam int HACT  = 24;
  localparam int VT    = 16;
  localparam int VS    = 2;
  localparam int VA    = 3;    // active lines 3..12
  localparam int VACT  = 10;
  localparam int FRAME = 4 * HT * VT;  // 2624 cycles

  logic       VCLK = 1'b0;
  logic       VRST = 1'b1;
  logic       EN = 1'b0;
  logic       INTERLACED = 1'b0;
  logic [1:0] PATTERN = 2'd0;
  logic       nVDSYNC;
  logic [6:0] VD;
  logic       FIELD;
  logic       FRAME_START;

  int n_tests = 0;
  int n_fail  = 0;
  int pos     = 0;

  n64_vbus_tx #(
    .H_TOTAL(HT), .H_SYNC(HS), .CLAMP_START(CS), .CLAMP_LEN(CL),
    .H_ACT_START(HA), .H_ACTIVE(HACT),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA), .V_ACTIVE(VACT)
  ) dut (
    .VCLK(VCLK),
    .VRST(VRST),
    .EN(EN),
    .INTERLACED(INTERLACED),
    .PATTERN(PATTERN),
    .nVDSYNC(nVDSYNC),
    .VD(VD),
    .FIELD(FIELD),
    .FRAME_START(FRAME_START)
  );

  always #5 VCLK = ~VCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic goto_pos(input int v, input int h, input int p);
    int target;
    target = 4 * (v * HT + h) + p;
    while (pos < target) begin
      @(negedge VCLK);
      pos++;
    end
  endtask

  // Bus value as {nVDSYNC, VD}.
  task automatic expect_bus(input string tag, input int v, input int h, input int p,
                            input logic [7:0] exp);
    goto_pos(v, h, p);
    check_eq(tag, 32'({nVDSYNC, VD}), 32'(exp));
  endtask

  task automatic expect_rgb(input string tag, input int v, input int h,
                            input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
    expect_bus({tag, "_r"}, v, h, 1, {1'b1, r});
    expect_bus({tag, "_g"}, v, h, 2, {1'b1, g});
    expect_bus({tag, "_b"}, v, h, 3, {1'b1, b});
  endtask

  // Waits (bounded) for the next FRAME_START and checks the frame period.
  task automatic wait_fs(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < FRAME + 64 && !seen; i++) begin
      @(negedge VCLK);
      pos++;
      if (FRAME_START) seen = 1'b1;
    end
    check_eq(tag, 32'(pos), 32'(FRAME));
    pos = 0;
  endtask

  initial begin
    int bad;

    // Reset values
    repeat (3) @(negedge VCLK);
    check_eq("rst_nvdsync", 32'(nVDSYNC), 32'd1);
    check_eq("rst_vd", 32'(VD), 32'h00);
    check_eq("rst_field", 32'(FIELD), 32'd0);
    check_eq("rst_frame_start", 32'(FRAME_START), 32'd0);

    VRST = 1'b0;
    repeat (3) @(negedge VCLK);
    check_eq("idle_bus", 32'({nVDSYNC, VD}), 32'h80);

    // EN rise: first output is the line 0 sync word with FRAME_START
    EN = 1'b1;
    @(negedge VCLK);
    pos = 0;
    check_eq("rise_fs", 32'(FRAME_START), 32'd1);
    check_eq("rise_sync_l0p0", 32'({nVDSYNC, VD}), 32'h05);

    // nVDSYNC low exactly on phase 0, FRAME_START only at pos 0, over line 0
    bad = 0;
    while (pos < 4 * HT) begin
      if (nVDSYNC !== ((pos % 4) != 0)) bad++;
      if (pos != 0 && FRAME_START !== 1'b0) bad++;
      @(negedge VCLK);
      pos++;
    end
    check_eq("cadence_errors", 32'(bad), 32'd0);

    // Frame A: 240p sync words, black
    expect_bus("a_serration_l1p6", 1, 6, 0, 8'h06);
    expect_bus("a_vs_end_l2p0", 2, 0, 0, 8'h0C);
    expect_bus("a_sync_l5p0", 5, 0, 0, 8'h0C);
    expect_bus("a_clamp_l5p6", 5, 6, 0, 8'h0B);
    expect_bus("a_black_l5p15", 5, 15, 1, 8'h80);
    PATTERN = 2'd1;
    expect_bus("a_pattern_hold", 6, 15, 1, 8'h80);
    wait_fs("a_period");

    // Frame B: colour bars
    expect_bus("b_vblank_l2p10", 2, 10, 1, 8'h80);
    expect_bus("b_before_act_l7p9", 7, 9, 1, 8'h80);
    expect_rgb("b_white", 7, 10, 7'h7F, 7'h7F, 7'h7F);
    expect_rgb("b_yellow", 7, 13, 7'h7F, 7'h7F, 7'h00);
    expect_rgb("b_green", 7, 19, 7'h00, 7'h7F, 7'h00);
    expect_bus("b_blue_b", 7, 30, 3, 8'hFF);
    expect_bus("b_black_last", 7, 33, 1, 8'h80);
    expect_bus("b_vend_l13p10", 13, 10, 1, 8'h80);
    PATTERN = 2'd2;
    wait_fs("b_period");

    // Frame C: grey ramp
    expect_bus("c_ramp_x5", 7, 15, 1, 8'h85);
    expect_bus("c_ramp_x23", 7, 33, 2, 8'h97);
    expect_bus("c_ramp_after", 7, 34, 1, 8'h80);
    PATTERN = 2'd3;
    wait_fs("c_period");

    // Frame D: checkerboard
    expect_bus("d_chk_x0y0", 3, 10, 1, 8'h80);
    expect_bus("d_chk_x8y0", 3, 18, 1, 8'hFF);
    expect_bus("d_chk_x0y8", 11, 10, 3, 8'hFF);
    expect_bus("d_chk_x8y8", 11, 18, 2, 8'h80);
    INTERLACED = 1'b1;
    wait_fs("d_period");

    // Frame E: field 1, vsync shifted by half a line
    check_eq("e_field", 32'(FIELD), 32'd1);
    expect_bus("e_sync_l0p0", 0, 0, 0, 8'h0C);
    expect_bus("e_sync_l0p19", 0, 19, 0, 8'h0F);
    expect_bus("e_vs_fall_l0p20", 0, 20, 0, 8'h06);
    expect_bus("e_vs_l1p3", 1, 3, 0, 8'h05);
    expect_bus("e_vs_l2p19", 2, 19, 0, 8'h06);
    expect_bus("e_vs_end_l2p20", 2, 20, 0, 8'h0F);
    wait_fs("e_period");

    // Frame F: back to field 0
    check_eq("f_field", 32'(FIELD), 32'd0);
    expect_bus("f_sync_l0p0", 0, 0, 0, 8'h05);
    INTERLACED = 1'b0;
    wait_fs("f_period");

    // Frame G: interlace dropped, field forced to 0
    check_eq("g_field_forced", 32'(FIELD), 32'd0);
    goto_pos(8, 18, 0);
    VRST = 1'b1;
    @(negedge VCLK);
    check_eq("vrst_bus", 32'({nVDSYNC, VD}), 32'h80);
    check_eq("vrst_fs", 32'(FRAME_START), 32'd0);
    VRST = 1'b0;
    @(negedge VCLK);
    pos = 0;
    check_eq("vrst_restart_fs", 32'(FRAME_START), 32'd1);
    check_eq("vrst_restart_sync", 32'({nVDSYNC, VD}), 32'h05);

    // EN drop mid-line, pattern picked up at the following rise
    goto_pos(8, 18, 0);
    EN = 1'b0;
    @(negedge VCLK);
    check_eq("en_drop_bus", 32'({nVDSYNC, VD}), 32'h80);
    PATTERN = 2'd2;
    repeat (2) @(negedge VCLK);
    EN = 1'b1;
    @(negedge VCLK);
    pos = 0;
    check_eq("en_rise_fs", 32'(FRAME_START), 32'd1);
    check_eq("en_rise_sync", 32'({nVDSYNC, VD}), 32'h05);
    expect_bus("en_rise_ramp_x5", 7, 15, 1, 8'h85);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
